// File: rtl/register_file_pkg.sv
// Shared helpers for the multi-port register file.
//   addr_width : address width for a given entry count (never below 1 bit)
//   byte_width : number of byte lanes in an entry
//   slice_lo   : low bit index of lane/port `idx` in a packed bus of `width`-bit fields
package register_file_pkg;

    localparam int BYTE_BITS = 8;

    function automatic int addr_width(input int num_address);
        int w;
        w = $clog2(num_address);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int byte_width(input int data_length);
        return data_length / BYTE_BITS;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/register_file_write_merge.sv
// Per-entry write merge. Given the entry's current contents and every write
// port, produces the value the entry holds after this edge.
//   i_current        : stored value of this entry
//   i_write_enable   : per-port write request
//   i_write_address  : packed write addresses
//   i_write_byte_en  : packed per-port byte enables
//   i_write_data     : packed write data
//   o_next           : merged next value (equals i_current when not hit)
//   o_hit            : at least one enabled port targets this entry
//   o_conflict       : two or more enabled ports target this entry
module register_file_write_merge
    import register_file_pkg::*;
#(
    parameter int NUM_WRITE   = 2,
    parameter int DATA_LENGTH = 32,
    parameter int AW          = 4,
    parameter int ENTRY_INDEX = 0,
    localparam int BW         = byte_width(DATA_LENGTH)
) (
    input  logic [DATA_LENGTH-1:0]           i_current,
    input  logic [NUM_WRITE-1:0]             i_write_enable,
    input  logic [NUM_WRITE*AW-1:0]          i_write_address,
    input  logic [NUM_WRITE*BW-1:0]          i_write_byte_en,
    input  logic [NUM_WRITE*DATA_LENGTH-1:0] i_write_data,
    output logic [DATA_LENGTH-1:0]           o_next,
    output logic                             o_hit,
    output logic                             o_conflict
);

    localparam logic [AW-1:0] ENTRY_ADDR = AW'(ENTRY_INDEX);

    logic [NUM_WRITE-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WRITE; gi++) begin : g_match
            assign w_match[gi] = i_write_enable[gi] &&
                (i_write_address[slice_lo(gi, AW) +: AW] == ENTRY_ADDR);
        end
    endgenerate

    assign o_hit = |w_match;
    // Clearing the lowest set bit leaves something only if two or more matched.
    assign o_conflict = |(w_match & (w_match - NUM_WRITE'(1)));

    // Ports applied in ascending order so the highest-indexed port wins each byte.
    always_comb begin
        o_next = i_current;
        for (int k = 0; k < NUM_WRITE; k++) begin
            for (int b = 0; b < BW; b++) begin
                if (w_match[k] && i_write_byte_en[slice_lo(k, BW) + b]) begin
                    o_next[slice_lo(b, BYTE_BITS) +: BYTE_BITS] =
                        i_write_data[slice_lo(k, DATA_LENGTH) + slice_lo(b, BYTE_BITS) +: BYTE_BITS];
                end
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_WRITE byte-enabled write ports merged per entry,
// NUM_READ independent read ports with optional write-to-read bypass and an
// optional output register, plus per-entry written-since-reset tracking.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   write_enable    : per-port write request
//   write_address   : packed write addresses (port k at [k*AW +: AW])
//   write_byte_en   : packed byte enables (port k at [k*BW +: BW])
//   write_data_in   : packed write data
//   read_address    : packed read addresses
//   read_data_out   : packed read data
//   read_valid      : entry at the read address written since reset
//   write_conflict  : two or more enabled writes hit the same in-range entry
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int NUM_ADDRESS  = 16,
    parameter int DATA_LENGTH  = 32,
    parameter int NUM_READ     = 2,
    parameter int NUM_WRITE    = 2,
    parameter int READ_LATENCY = 0,
    parameter int BYPASS       = 1,
    localparam int AW          = addr_width(NUM_ADDRESS),
    localparam int BW          = byte_width(DATA_LENGTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WRITE-1:0]             write_enable,
    input  logic [NUM_WRITE*AW-1:0]          write_address,
    input  logic [NUM_WRITE*BW-1:0]          write_byte_en,
    input  logic [NUM_WRITE*DATA_LENGTH-1:0] write_data_in,
    input  logic [NUM_READ*AW-1:0]           read_address,
    output logic [NUM_READ*DATA_LENGTH-1:0]  read_data_out,
    output logic [NUM_READ-1:0]              read_valid,
    output logic                             write_conflict
);

    localparam bit USE_BYPASS = (BYPASS != 0);

    logic [DATA_LENGTH-1:0] r_mem [NUM_ADDRESS];
    logic [NUM_ADDRESS-1:0] r_written;

    logic [DATA_LENGTH-1:0] w_next [NUM_ADDRESS];
    logic [NUM_ADDRESS-1:0] w_hit;
    logic [NUM_ADDRESS-1:0] w_conflict_entry;
    logic                   w_conflict;

    genvar gi;

    // One merge per entry. Out-of-range write addresses match no entry, so they
    // are dropped and never count as a conflict.
    generate
        for (gi = 0; gi < NUM_ADDRESS; gi++) begin : g_entry
            register_file_write_merge #(
                .NUM_WRITE   (NUM_WRITE),
                .DATA_LENGTH (DATA_LENGTH),
                .AW          (AW),
                .ENTRY_INDEX (gi)
            ) u_merge (
                .i_current       (r_mem[gi]),
                .i_write_enable  (write_enable),
                .i_write_address (write_address),
                .i_write_byte_en (write_byte_en),
                .i_write_data    (write_data_in),
                .o_next          (w_next[gi]),
                .o_hit           (w_hit[gi]),
                .o_conflict      (w_conflict_entry[gi])
            );
        end
    endgenerate

    assign w_conflict = |w_conflict_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ADDRESS; i++) begin
                r_mem[i] <= '0;
            end
            r_written <= '0;
        end else begin
            for (int i = 0; i < NUM_ADDRESS; i++) begin
                r_mem[i] <= w_next[i];
            end
            r_written <= r_written | w_hit;
        end
    end

    // Read ports. The bypass path forwards the same merged value that is about
    // to be stored, so forwarded and stored data cannot diverge.
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [AW-1:0]          w_addr;
            logic [DATA_LENGTH-1:0] w_data;
            logic                   w_valid;

            assign w_addr = read_address[slice_lo(gi, AW) +: AW];

            // One-hot scan over existing entries: an address past the last
            // entry matches nothing and reads as 0 / not valid.
            always_comb begin
                w_data  = '0;
                w_valid = 1'b0;
                for (int e = 0; e < NUM_ADDRESS; e++) begin
                    if (w_addr == AW'(e)) begin
                        w_data  = USE_BYPASS ? w_next[e] : r_mem[e];
                        w_valid = r_written[e] | (USE_BYPASS & w_hit[e]);
                    end
                end
            end

            if (READ_LATENCY == 1) begin : g_reg
                logic [DATA_LENGTH-1:0] r_data;
                logic                   r_valid;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_data  <= '0;
                        r_valid <= 1'b0;
                    end else begin
                        r_data  <= w_data;
                        r_valid <= w_valid;
                    end
                end

                assign read_data_out[slice_lo(gi, DATA_LENGTH) +: DATA_LENGTH] = r_data;
                assign read_valid[gi] = r_valid;
            end else begin : g_comb
                assign read_data_out[slice_lo(gi, DATA_LENGTH) +: DATA_LENGTH] = w_data;
                assign read_valid[gi] = w_valid;
            end
        end
    endgenerate

    generate
        if (READ_LATENCY == 1) begin : g_conflict_reg
            logic r_conflict;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_conflict <= 1'b0;
                end else begin
                    r_conflict <= w_conflict;
                end
            end

            assign write_conflict = r_conflict;
        end else begin : g_conflict_comb
            assign write_conflict = w_conflict;
        end
    endgenerate

endmodule
